// File: rtl/pattern_pkg.sv
// Shared state encoding, dim limits and default parameters for the pattern sequencer.
package pattern_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_FADE_OUT = 2'd1;
  localparam logic [1:0] ST_SWITCH   = 2'd2;
  localparam logic [1:0] ST_FADE_IN  = 2'd3;

  typedef enum logic [1:0] {
    RUN      = ST_RUN,
    FADE_OUT = ST_FADE_OUT,
    SWITCH   = ST_SWITCH,
    FADE_IN  = ST_FADE_IN
  } state_t;

  localparam logic [1:0] DIM_MAX = 2'd3;

  localparam int NUM_PATTERNS_DEF    = 6;
  localparam int DWELL_FRAMES_DEF    = 600;
  localparam int FADE_FRAMES_DEF     = 4;
  localparam int DEBOUNCE_FRAMES_DEF = 3;

endpackage

// File: rtl/frame_debounce.sv
// Synchronises a raw button and emits one press pulse on the frame strobe where it has been high FRAMES frames.
// Pulse is combinational with next_frame; holding the button gives no repeat until release.
module frame_debounce
  import pattern_pkg::*;
#(
  parameter int FRAMES = DEBOUNCE_FRAMES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic next_frame,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(FRAMES) + 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b00;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], raw};
      if (!sync[1]) begin
        cnt <= '0;
      end else if (next_frame && (cnt != CW'(FRAMES))) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Fires only on the strobe that moves the counter onto its saturation value.
  assign press = next_frame & sync[1] & (cnt == CW'(FRAMES - 1));

endmodule

// File: rtl/pattern_sequencer.sv
// Selects the active pattern generator and sequences dim-out / switch / dim-in on frame strobes.
// All state changes land on next_frame; requests arriving mid-transition are held in a 1-deep pending flag.
module pattern_sequencer
  import pattern_pkg::*;
#(
  parameter int NUM_PATTERNS    = NUM_PATTERNS_DEF,
  parameter int DWELL_FRAMES    = DWELL_FRAMES_DEF,
  parameter int FADE_FRAMES     = FADE_FRAMES_DEF,
  parameter int DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    next_frame,
  input  logic                    btn_next,
  input  logic                    auto_en,
  input  logic [2:0]              speed_in,
  output logic [2:0]              pattern_idx,
  output logic [NUM_PATTERNS-1:0] pattern_enable,
  output logic [2:0]              step_size,
  output logic [1:0]              dim_level,
  output logic                    busy
);

  localparam int FW = $clog2(FADE_FRAMES) + 1;
  localparam int DW = $clog2(DWELL_FRAMES) + 1;

  state_t        state;
  logic [FW-1:0] fade_cnt;
  logic [DW-1:0] dwell_cnt;
  logic          pending;
  logic          press;
  logic          auto_req;
  logic          req;
  logic          fade_last;
  logic [2:0]    next_idx;

  frame_debounce #(
    .FRAMES (DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .next_frame (next_frame),
    .raw        (btn_next),
    .press      (press)
  );

  assign auto_req  = next_frame & auto_en & (state == RUN) & (dwell_cnt == DW'(DWELL_FRAMES - 1));
  assign req       = press | auto_req;
  assign fade_last = (fade_cnt == FW'(FADE_FRAMES - 1));
  assign next_idx  = (pattern_idx == 3'(NUM_PATTERNS - 1)) ? 3'd0 : pattern_idx + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt <= '0;
      step_size <= 3'd1;
    end else if (next_frame) begin
      step_size <= speed_in;
      if ((state != RUN) || !auto_en || auto_req) begin
        dwell_cnt <= '0;
      end else begin
        dwell_cnt <= dwell_cnt + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      fade_cnt    <= '0;
      dim_level   <= 2'd0;
      pattern_idx <= 3'd0;
      busy        <= 1'b0;
      pending     <= 1'b0;
    end else if (next_frame) begin
      // A second request while one is already pending is simply absorbed.
      if ((state != RUN) && req) begin
        pending <= 1'b1;
      end
      case (state)
        RUN: begin
          if (req || pending) begin
            state     <= FADE_OUT;
            fade_cnt  <= '0;
            dim_level <= 2'd1;
            busy      <= 1'b1;
            pending   <= 1'b0;
          end
        end
        FADE_OUT: begin
          if (fade_last) begin
            fade_cnt <= '0;
            if (dim_level == DIM_MAX) begin
              state       <= SWITCH;
              pattern_idx <= next_idx;
            end else begin
              dim_level <= dim_level + 2'd1;
            end
          end else begin
            fade_cnt <= fade_cnt + FW'(1);
          end
        end
        SWITCH: begin
          state    <= FADE_IN;
          fade_cnt <= '0;
        end
        FADE_IN: begin
          if (fade_last) begin
            fade_cnt  <= '0;
            dim_level <= dim_level - 2'd1;
            if (dim_level == 2'd1) begin
              state <= RUN;
              busy  <= 1'b0;
            end
          end else begin
            fade_cnt <= fade_cnt + FW'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    pattern_enable = '0;
    for (int i = 0; i < NUM_PATTERNS; i++) begin
      if (pattern_idx == 3'(i)) pattern_enable[i] = 1'b1;
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer with a short dwell so auto-advance fits in a small run.
module tb_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       next_frame = 1'b0;
  logic       btn_next = 1'b0;
  logic       auto_en = 1'b0;
  logic [2:0] speed_in = 3'd1;
  logic [2:0] pattern_idx;
  logic [5:0] pattern_enable;
  logic [2:0] step_size;
  logic [1:0] dim_level;
  logic       busy;

  int checks = 0;
  int errors = 0;

  pattern_sequencer #(
    .NUM_PATTERNS    (6),
    .DWELL_FRAMES    (8),
    .FADE_FRAMES     (4),
    .DEBOUNCE_FRAMES (3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .next_frame     (next_frame),
    .btn_next       (btn_next),
    .auto_en        (auto_en),
    .speed_in       (speed_in),
    .pattern_idx    (pattern_idx),
    .pattern_enable (pattern_enable),
    .step_size      (step_size),
    .dim_level      (dim_level),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // One frame: idle cycles (lets the synchroniser settle), then a single-cycle strobe.
  task automatic frame();
    repeat (3) @(negedge clk);
    next_frame = 1'b1;
    @(negedge clk);
    next_frame = 1'b0;
  endtask

  // Dim level j frames after a transition starts: 4x1, 4x2, 9x3 (incl. SWITCH), 4x2, 4x1.
  function automatic int dim_at(input int j);
    if (j < 0 || j >= 25) return 0;
    if (j < 4)  return 1;
    if (j < 8)  return 2;
    if (j < 17) return 3;
    if (j < 21) return 2;
    return 1;
  endfunction

  task automatic chk_outputs(input string tag, input int e_dim, input int e_idx, input int e_busy);
    chk({tag, " dim"}, 16'(dim_level), 16'(e_dim));
    chk({tag, " idx"}, 16'(pattern_idx), 16'(e_idx));
    chk({tag, " en"}, 16'(pattern_enable), 16'(1 << e_idx));
    chk({tag, " busy"}, 16'(busy), 16'(e_busy));
  endtask

  // Drives btn_next from mask[f] before frame f; s1/s2 are frames where transitions are expected to start.
  task automatic run_seq(input string tag, input logic [63:0] mask, input int s1, input int s2,
                         input int idx0, input int n);
    int e_dim, e_busy, adv, j;
    for (int f = 1; f <= n; f++) begin
      btn_next = mask[f];
      frame();
      e_dim = 0; e_busy = 0; adv = 0;
      if (s1 > 0) begin
        j = f - s1;
        if (j >= 0 && j < 25) begin e_dim = dim_at(j); e_busy = 1; end
        if (j >= 12) adv++;
      end
      if (s2 > 0) begin
        j = f - s2;
        if (j >= 0 && j < 25) begin e_dim = dim_at(j); e_busy = 1; end
        if (j >= 12) adv++;
      end
      chk_outputs($sformatf("%s f%0d", tag, f), e_dim, (idx0 + adv) % 6, e_busy);
    end
    btn_next = 1'b0;
  endtask

  initial begin
    int j, n, r, e_dim, e_busy, e_idx;

    repeat (3) @(negedge clk);
    chk_outputs("reset", 0, 0, 0);
    chk("reset step", 16'(step_size), 16'd1);
    rst_n = 1'b1;

    run_seq("idle", 64'h0, -1, -1, 0, 10);
    run_seq("press", 64'h3E, 3, -1, 0, 32);
    run_seq("glitch", 64'h2, -1, -1, 1, 8);
    run_seq("pending", 64'h0077_000E, 3, 29, 1, 60);

    // Speed change mid-frame must wait for the next strobe.
    repeat (2) @(negedge clk);
    speed_in = 3'd5;
    repeat (2) @(negedge clk);
    chk("speed midframe", 16'(step_size), 16'd1);
    frame();
    chk("speed after frame", 16'(step_size), 16'd5);

    // Reset asserted during the SWITCH frame.
    run_seq("to_switch", 64'hE, 3, -1, 3, 15);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_outputs("rst in switch", 0, 0, 0);
    chk("rst in switch step", 16'(step_size), 16'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_seq("after rst", 64'hE, 3, -1, 0, 30);

    // Auto-advance: first start at frame 8, then every 33 frames; auto_en dropped mid 6th transition.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    auto_en = 1'b1;
    for (int f = 1; f <= 215; f++) begin
      if (f == 180) auto_en = 1'b0;
      frame();
      j = f - 8;
      if (j < 0) begin
        e_dim = 0; e_busy = 0; e_idx = 0;
      end else begin
        n = j / 33;
        r = j % 33;
        if (n > 5) begin n = 5; r = 33; end
        e_dim  = dim_at(r);
        e_busy = (r < 25) ? 1 : 0;
        e_idx  = (n + ((r >= 12) ? 1 : 0)) % 6;
      end
      chk_outputs($sformatf("auto f%0d", f), e_dim, e_idx, e_busy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
